// File: rtl/rolfmobile99_pkg.sv
// rolfmobile99_pkg: shared constants for the rolfmobile99 pad map and debounce default
package rolfmobile99_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int N_IO = 8;
  localparam int CLK_BIT = 7;
  localparam int RST_BIT = 6;
  localparam int XNOR_A_BIT = 5;
  localparam int XNOR_B_BIT = 4;
endpackage

// File: rtl/rolfmobile99_debounce_ch.sv
// rolfmobile99_debounce_ch: one channel of 2-flop sync, persistence counter, level and edge flops
// Edge flops built only when ROLFMOBILE99_DEBOUNCE_EDGE_EN is defined.
module rolfmobile99_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, chg, term, accept;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    chg = s2 != level;
    term = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    accept = chg && term;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (chg && !term) ? cnt + 1'b1 : '0;
      if (accept) level <= s2;
    end
  end
`ifdef ROLFMOBILE99_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/rolfmobile99_debounce.sv
// rolfmobile99_debounce: synchronised, debounced pad inputs feeding the XNOR stage
// Optional rise/fall pulses via ROLFMOBILE99_DEBOUNCE_EDGE_EN.
module rolfmobile99_debounce
  import rolfmobile99_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rolfmobile99_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(raw_in[i]),
      .level(level_out[i]),
      .rise(rise_out[i]),
      .fall(fall_out[i])
    );
  end
endmodule

// File: tb/tb_rolfmobile99_debounce.sv
// tb_rolfmobile99_debounce: directed checks of the debouncer at D=4 and D=1
module tb_rolfmobile99_debounce;
`ifdef ROLFMOBILE99_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] raw = 2'b00, raw1 = 2'b00;
  logic [1:0] level, rise, fall, level1, rise1, fall1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  rolfmobile99_debounce #(.N_CH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .raw_in(raw),
    .level_out(level), .rise_out(rise), .fall_out(fall)
  );
  rolfmobile99_debounce #(.N_CH(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .raw_in(raw1),
    .level_out(level1), .rise_out(rise1), .fall_out(fall1)
  );
  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    // reset held 2 clocks with raw high
    raw = 2'b11;
    tick();
    check("rst_level", level, 2'b00);
    tick();
    check("rst_level2", level, 2'b00);
    check("rst_rise", rise, 2'b00);
    check("rst_fall", fall, 2'b00);
    check("rst_level_d1", level1, 2'b00);
    reset = 1'b0;
    tick(5);
    check("rel_pre", level, 2'b00);
    tick();
    check("rel_level", level, 2'b11);
    check("rel_rise", rise, EDGE ? 2'b11 : 2'b00);
    tick();
    check("rel_rise_off", rise, 2'b00);
    // simultaneous fall on both channels
    raw = 2'b00;
    tick(5);
    check("sim_pre", level, 2'b11);
    check("sim_pre_fall", fall, 2'b00);
    tick();
    check("sim_level", level, 2'b00);
    check("sim_fall", fall, EDGE ? 2'b11 : 2'b00);
    check("sim_rise", rise, 2'b00);
    tick();
    check("sim_fall_off", fall, 2'b00);
    // clean step on channel 0 only
    raw = 2'b01;
    tick(5);
    check("step_pre", level, 2'b00);
    tick();
    check("step_level", level, 2'b01);
    check("step_rise", rise, EDGE ? 2'b01 : 2'b00);
    tick();
    check("step_rise_off", rise, 2'b00);
    check("step_hold", level, 2'b01);
    // 3-clock glitch on channel 1 must be rejected
    raw = 2'b11;
    tick(3);
    raw = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_level", level, 2'b01);
      check("glitch_rise", rise, 2'b00);
    end
    // mid-count reset discards the count
    reset = 1'b1;
    raw = 2'b00;
    tick();
    reset = 1'b0;
    tick(3);
    raw = 2'b01;
    tick(3);
    reset = 1'b1;
    tick();
    check("mid_rst_level", level, 2'b00);
    check("mid_rst_rise", rise, 2'b00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_wait", level, 2'b00);
    end
    tick();
    check("mid_level", level, 2'b01);
    check("mid_rise", rise, EDGE ? 2'b01 : 2'b00);
    // D=1: latency 3 clocks
    raw1 = 2'b01;
    tick();
    check("d1_e0", level1, 2'b00);
    tick();
    check("d1_e1", level1, 2'b00);
    tick();
    check("d1_e2", level1, 2'b01);
    check("d1_rise", rise1, EDGE ? 2'b01 : 2'b00);
    raw1 = 2'b10;
    tick(2);
    check("d1_hold", level1, 2'b01);
    tick();
    check("d1_swap", level1, 2'b10);
    check("d1_fall", fall1, EDGE ? 2'b01 : 2'b00);
    check("d1_rise2", rise1, EDGE ? 2'b10 : 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
